// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch slice: fetch latency, buffer entries
// and the tag that travels alongside each outstanding memory request.
package fetch_pkg;
   localparam int FETCH_LATENCY = 2;

   typedef logic [31:0] instr_t;

   typedef struct packed {
      logic [31:0] pc;
      instr_t      instr;
   } fetch_entry_t;

   typedef struct packed {
      logic        valid;
      logic        stale;
      logic [31:0] pc;
   } fetch_tag_t;
endpackage

// File: rtl/program_memory_bus.sv
// Program memory read bus: word address and request out, instruction back
// after a fixed latency.
interface program_memory_bus;
   logic [31:0] addr;
   logic        read_request;
   logic [31:0] instr;
   logic        data_valid;

   modport CONSUMER (output addr, output read_request, input instr, input data_valid);
   modport PROVIDER (input addr, input read_request, output instr, output data_valid);
endinterface

// File: rtl/fetch_fifo.sv
// Instruction buffer: synchronous FIFO of fetch entries with flush, a
// registered head entry and an occupancy count.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk_in,
   input  logic                     rst_n_in,
   input  logic                     flush,
   input  logic                     push,
   input  fetch_entry_t             push_data,
   input  logic                     pop,
   output fetch_entry_t             head,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t   store [DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr, rd_nxt;
   logic           do_pop;

   assign do_pop = pop && (count != '0);
   assign rd_nxt = rd_ptr + AW'(1);

   always_ff @(posedge clk_in)
      if (push) store[wr_ptr] <= push_data;

   always_ff @(posedge clk_in) begin
      if (!rst_n_in || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head   <= '0;
      end else begin
         assert (!(push && count == CW'(DEPTH)));
         if (push)   wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) rd_ptr <= rd_nxt;
         count <= count + CW'(push) - CW'(do_pop);
         // Head takes the incoming entry when it lands in an otherwise empty buffer.
         if (push && count == (do_pop ? CW'(1) : CW'(0)))
            head <= push_data;
         else if (do_pop && count > CW'(1))
            head <= store[rd_nxt];
      end
   end
endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: issues sequential word reads under a credit limit, tags
// them through the memory latency and buffers returned instructions for decode.
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic                       clk_in,
   input  logic                       rst_n_in,
   program_memory_bus.CONSUMER        mem,
   input  logic                       fetch_enable_in,
   input  logic                       redirect_valid_in,
   input  logic [31:0]                redirect_pc_in,
   output logic                       instr_valid_out,
   output logic [31:0]                instr_out,
   output logic [31:0]                instr_pc_out,
   input  logic                       instr_ready_in
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]   fetch_pc;
   fetch_tag_t    tag_pipe [1:FETCH_LATENCY];
   logic [1:0]    in_flight;
   logic [CW-1:0] fifo_count;
   logic [CW-1:0] credit_used;
   logic          issue, push, pop;
   fetch_entry_t  head;

   always_comb begin
      in_flight = '0;
      for (int s = 1; s <= FETCH_LATENCY; s++)
         in_flight = in_flight + 2'(tag_pipe[s].valid);
      credit_used = CW'(in_flight) + fifo_count;
      issue = rst_n_in && fetch_enable_in && !redirect_valid_in &&
              (credit_used < CW'(FIFO_DEPTH));
      push  = rst_n_in && !redirect_valid_in && mem.data_valid &&
              tag_pipe[FETCH_LATENCY].valid && !tag_pipe[FETCH_LATENCY].stale;
      pop   = instr_valid_out && instr_ready_in && !redirect_valid_in;
   end

   assign mem.addr         = {2'b00, fetch_pc[31:2]};
   assign mem.read_request = issue;

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         fetch_pc <= RESET_PC;
         for (int s = 1; s <= FETCH_LATENCY; s++) tag_pipe[s] <= '0;
      end else begin
         if (redirect_valid_in)
            fetch_pc <= redirect_pc_in & ~32'd3;
         else if (issue)
            fetch_pc <= fetch_pc + 32'd4;
         tag_pipe[1] <= '{valid: issue, stale: 1'b0, pc: fetch_pc};
         // A redirect poisons everything already in flight; those responses are dropped.
         for (int s = 2; s <= FETCH_LATENCY; s++) begin
            tag_pipe[s]       <= tag_pipe[s-1];
            tag_pipe[s].stale <= tag_pipe[s-1].stale | redirect_valid_in;
         end
      end
   end

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .flush     (redirect_valid_in),
      .push      (push),
      .push_data ('{pc: tag_pipe[FETCH_LATENCY].pc, instr: mem.instr}),
      .pop       (pop),
      .head      (head),
      .count     (fifo_count)
   );

   // Outputs read as zero for the whole reset-low cycle, not just after the edge.
   assign instr_valid_out = rst_n_in && (fifo_count != '0);
   assign instr_out       = rst_n_in ? head.instr : 32'h0;
   assign instr_pc_out    = rst_n_in ? head.pc    : 32'h0;
endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized scoreboard bench for instruction_fetch with a 2-cycle memory model.
module tb_instruction_fetch;
   import fetch_pkg::*;

   localparam int FIFO_DEPTH = 4;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        fetch_enable_in;
   logic        redirect_valid_in;
   logic [31:0] redirect_pc_in;
   logic        instr_valid_out;
   logic [31:0] instr_out;
   logic [31:0] instr_pc_out;
   logic        instr_ready_in;

   int checks = 0;
   int errors = 0;
   int total_deliv = 0;

   program_memory_bus bus ();

   instruction_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk_in            (clk_in),
      .rst_n_in          (rst_n_in),
      .mem               (bus),
      .fetch_enable_in   (fetch_enable_in),
      .redirect_valid_in (redirect_valid_in),
      .redirect_pc_in    (redirect_pc_in),
      .instr_valid_out   (instr_valid_out),
      .instr_out         (instr_out),
      .instr_pc_out      (instr_pc_out),
      .instr_ready_in    (instr_ready_in)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a * 32'h9E37_79B1 + 32'h1357_9BDF;
   endfunction

   // Memory: fixed two-cycle latency, never reset alongside fetch.
   logic        d1_v = 1'b0, d2_v = 1'b0;
   logic [31:0] d1_a = '0, d2_a = '0;
   always @(posedge clk_in) begin
      d1_v <= bus.read_request;
      d1_a <= bus.addr;
      d2_v <= d1_v;
      d2_a <= d1_a;
   end
   assign bus.data_valid = d2_v;
   assign bus.instr      = d2_v ? mem_word(d2_a) : 32'hDEAD_BEEF;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Reference: after reset or redirect to X, decode sees X, X+4, ... in order.
   fetch_entry_t exp_q[$];
   logic [31:0]  model_pc = 32'h0;
   logic         prev_flush = 1'b0;

   function automatic void fill();
      while (exp_q.size() < 8) begin
         exp_q.push_back('{pc: model_pc, instr: mem_word(model_pc >> 2)});
         model_pc = model_pc + 32'd4;
      end
   endfunction

   always @(negedge clk_in) begin
      if (!rst_n_in) begin
         chk("rst_valid", 32'(instr_valid_out), 32'd0);
         chk("rst_instr", instr_out, 32'd0);
         chk("rst_pc", instr_pc_out, 32'd0);
         chk("rst_req", 32'(bus.read_request), 32'd0);
         exp_q.delete();
         model_pc = 32'h0;
         fill();
         prev_flush = 1'b0;
      end else begin
         if (!fetch_enable_in || redirect_valid_in)
            chk("req_gated", 32'(bus.read_request), 32'd0);
         if (prev_flush)
            chk("flush_empty", 32'(instr_valid_out), 32'd0);
         if (redirect_valid_in) begin
            exp_q.delete();
            model_pc = redirect_pc_in & ~32'd3;
            fill();
         end else if (instr_valid_out && instr_ready_in) begin
            if (exp_q.size() == 0) begin
               chk("sb_empty", 32'd1, 32'd0);
            end else begin
               chk("pc", instr_pc_out, exp_q[0].pc);
               chk("instr", instr_out, exp_q[0].instr);
               void'(exp_q.pop_front());
               total_deliv++;
               fill();
            end
         end
         prev_flush = redirect_valid_in;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      redirect_valid_in = 1'b1;
      redirect_pc_in    = pc;
      step(1);
      redirect_valid_in = 1'b0;
   endtask

   int issued, deliv;

   initial begin
      rst_n_in          = 1'b0;
      fetch_enable_in   = 1'b1;
      redirect_valid_in = 1'b0;
      redirect_pc_in    = '0;
      instr_ready_in    = 1'b1;
      repeat (3) @(posedge clk_in);
      #1 rst_n_in = 1'b1;

      // Startup: word addresses 0,1,2,... from the first cycle, data visible from cycle 3.
      for (int k = 0; k < 6; k++) begin
         @(negedge clk_in);
         chk("start_req", 32'(bus.read_request), 32'd1);
         chk("start_addr", bus.addr, 32'(k));
         chk("start_valid", 32'(instr_valid_out), (k >= 3) ? 32'd1 : 32'd0);
         @(posedge clk_in);
         #1;
      end

      // Redirect with a partly full buffer and responses in flight.
      instr_ready_in = 1'b0;
      step(2);
      redirect_to(32'h0000_0100);
      instr_ready_in = 1'b1;
      step(12);

      // Redirect coinciding with a pop and a returning response.
      redirect_to(32'h0000_4002);
      step(10);

      // Wrap across the top of the address space.
      redirect_to(32'hFFFF_FFF8);
      step(12);

      // One-cycle reset with requests outstanding.
      rst_n_in = 1'b0;
      step(1);
      rst_n_in = 1'b1;
      step(12);

      // Decode stall: outstanding work saturates at the buffer depth.
      redirect_to(32'h0000_2000);
      issued = 0;
      deliv  = 0;
      for (int c = 0; c < 16; c++) begin
         instr_ready_in = (c < 6);
         @(negedge clk_in);
         issued += 32'(bus.read_request);
         deliv  += 32'(instr_valid_out && instr_ready_in);
         chk("credit", 32'(issued - deliv <= FIFO_DEPTH), 32'd1);
         if (c == 15) begin
            chk("stall_req", 32'(bus.read_request), 32'd0);
            chk("stall_outstanding", 32'(issued - deliv), 32'(FIFO_DEPTH));
         end
         @(posedge clk_in);
         #1;
      end
      instr_ready_in = 1'b1;
      step(10);

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         rst_n_in          = ($urandom_range(0, 399) != 0);
         fetch_enable_in   = ($urandom_range(0, 99) < 85);
         instr_ready_in    = ($urandom_range(0, 99) < 70);
         redirect_valid_in = ($urandom_range(0, 99) < 3);
         redirect_pc_in    = ($urandom_range(0, 3) == 0) ?
                             32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
         step(1);
      end

      rst_n_in          = 1'b1;
      redirect_valid_in = 1'b0;
      fetch_enable_in   = 1'b0;
      instr_ready_in    = 1'b1;
      step(10);
      chk("progress", 32'(total_deliv > 500), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
